// File: rtl/traffic_phase_controller.sv
// Four-way intersection sequencer with a pedestrian phase, timed by an internal
// clock-enable prescaler so every flop runs on the single board clock.
module traffic_phase_controller #(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned GREEN_TICKS  = 10,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned WALK_TICKS   = 5
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic       tick,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    AR_A = 3'd0,
    NS_G = 3'd1,
    NS_Y = 3'd2,
    AR_B = 3'd3,
    EW_G = 3'd4,
    EW_Y = 3'd5,
    WALK = 3'd6
  } state_e;

  localparam logic [31:0] PCNT_MAX  = 32'(TICK_DIV - 1);
  localparam logic [7:0]  GREEN_LD  = 8'(GREEN_TICKS - 1);
  localparam logic [7:0]  YELLOW_LD = 8'(YELLOW_TICKS - 1);
  localparam logic [7:0]  ALLRED_LD = 8'(ALLRED_TICKS - 1);
  localparam logic [7:0]  WALK_LD   = 8'(WALK_TICKS - 1);
  localparam logic [2:0]  LAMP_RED  = 3'b100;
  localparam logic [2:0]  LAMP_YEL  = 3'b010;
  localparam logic [2:0]  LAMP_GRN  = 3'b001;

  state_e      state_q, state_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic [7:0]  ptmr_q, ptmr_d;
  logic        pend_q, pend_d;
  logic        ped_ack_q, ped_ack_d;
  logic [2:0]  ns_light_q, ns_light_d;
  logic [2:0]  ew_light_q, ew_light_d;
  logic        walk_q, walk_d;
  logic        accept;
  logic        illegal;

  function automatic logic [7:0] load_val(input state_e s);
    case (s)
      NS_G, EW_G: load_val = GREEN_LD;
      NS_Y, EW_Y: load_val = YELLOW_LD;
      WALK:       load_val = WALK_LD;
      default:    load_val = ALLRED_LD;
    endcase
  endfunction

  assign tick    = en && (pcnt_q == PCNT_MAX);
  assign accept  = ped_req && !pend_q && (state_q != WALK);
  assign illegal = (state_q > WALK);

  always_comb begin
    pcnt_d    = pcnt_q;
    ptmr_d    = ptmr_q;
    state_d   = state_q;
    pend_d    = pend_q | accept;
    ped_ack_d = accept;

    if (en) begin
      pcnt_d = (pcnt_q == PCNT_MAX) ? 32'd0 : pcnt_q + 32'd1;
    end

    if (tick) begin
      if (ptmr_q == 8'd0 || illegal) begin
        case (state_q)
          AR_A:    state_d = NS_G;
          NS_G:    state_d = NS_Y;
          NS_Y:    state_d = AR_B;
          AR_B:    state_d = EW_G;
          EW_G:    state_d = EW_Y;
          // A request landing in the final EW_Y tick cycle is still served now
          EW_Y:    state_d = (pend_q || accept) ? WALK : AR_A;
          default: state_d = AR_A;
        endcase
        ptmr_d = load_val(state_d);
      end else begin
        ptmr_d = ptmr_q - 8'd1;
      end
    end

    if (state_d == WALK && state_q != WALK) begin
      pend_d = 1'b0;
    end

    // Lamps are registered from the next state so they track state_q exactly
    ns_light_d = LAMP_RED;
    ew_light_d = LAMP_RED;
    case (state_d)
      NS_G:    ns_light_d = LAMP_GRN;
      NS_Y:    ns_light_d = LAMP_YEL;
      EW_G:    ew_light_d = LAMP_GRN;
      EW_Y:    ew_light_d = LAMP_YEL;
      default: ;
    endcase
    walk_d = (state_d == WALK);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= AR_A;
      pcnt_q     <= 32'd0;
      ptmr_q     <= ALLRED_LD;
      pend_q     <= 1'b0;
      ped_ack_q  <= 1'b0;
      ns_light_q <= LAMP_RED;
      ew_light_q <= LAMP_RED;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      ptmr_q     <= ptmr_d;
      pend_q     <= pend_d;
      ped_ack_q  <= ped_ack_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
      walk_q     <= walk_d;
    end
  end

  assign ped_ack  = ped_ack_q;
  assign ns_light = ns_light_q;
  assign ew_light = ew_light_q;
  assign walk     = walk_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Self-checking bench for traffic_phase_controller: directed scenarios plus a
// randomized run, all checked against a phase-schedule reference model.
module tb_traffic_phase_controller;

  localparam int DIV = 4;
  localparam int GT  = 3;
  localparam int YT  = 2;
  localparam int AT  = 1;
  localparam int WT  = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, ped_req;
  logic       ped_ack, tick, walk;
  logic [2:0] ns_light, ew_light, phase;

  logic       mx_rst_n, mx_en, mx_ped_req;
  logic       mx_ped_ack, mx_tick, mx_walk;
  logic [2:0] mx_ns_light, mx_ew_light, mx_phase;

  traffic_phase_controller #(
    .TICK_DIV(DIV), .GREEN_TICKS(GT), .YELLOW_TICKS(YT),
    .ALLRED_TICKS(AT), .WALK_TICKS(WT)
  ) dut (
    .clk_in(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req),
    .ped_ack(ped_ack), .tick(tick), .ns_light(ns_light),
    .ew_light(ew_light), .walk(walk), .phase(phase)
  );

  traffic_phase_controller #(
    .TICK_DIV(2), .GREEN_TICKS(255)
  ) dut_max (
    .clk_in(clk), .rst_n(mx_rst_n), .en(mx_en), .ped_req(mx_ped_req),
    .ped_ack(mx_ped_ack), .tick(mx_tick), .ns_light(mx_ns_light),
    .ew_light(mx_ew_light), .walk(mx_walk), .phase(mx_phase)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: phase index, ticks left in the phase, prescaler position
  int   m_cnt, m_phase, m_left;
  logic m_pend, m_ack;

  wire [11:0] dut_obs = {tick, ped_ack, walk, ns_light, ew_light, phase};

  function automatic int dur(input int p);
    case (p)
      1, 4:    return GT;
      2, 5:    return YT;
      6:       return WT;
      default: return AT;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_phase = 0;
    m_left  = dur(0);
    m_pend  = 1'b0;
    m_ack   = 1'b0;
  endtask

  task automatic model_step();
    logic t, acc;
    t   = en && (m_cnt == DIV - 1);
    acc = ped_req && !m_pend && (m_phase != 6);
    m_ack = acc;
    if (acc) m_pend = 1'b1;
    if (t) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_phase == 5)      m_phase = m_pend ? 6 : 0;
        else if (m_phase == 6) m_phase = 0;
        else                   m_phase = m_phase + 1;
        if (m_phase == 6) m_pend = 1'b0;
        m_left = dur(m_phase);
      end
    end
    if (en) m_cnt = (m_cnt + 1) % DIV;
  endtask

  function automatic logic [11:0] model_obs();
    logic [2:0] ns, ew;
    logic       t, w;
    ns = (m_phase == 1) ? 3'b001 : (m_phase == 2) ? 3'b010 : 3'b100;
    ew = (m_phase == 4) ? 3'b001 : (m_phase == 5) ? 3'b010 : 3'b100;
    t  = en && (m_cnt == DIV - 1);
    w  = (m_phase == 6);
    return {t, m_ack, w, ns, ew, 3'(m_phase)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    en      = 1'b1;
    ped_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int g;
    g = 0;
    while (phase !== p && g < 200) begin
      step();
      g++;
    end
    checks++;
    if (phase !== p) begin
      errors++;
      $display("FAIL wait_phase: phase=%0d required=%0d within 200 cycles", phase, p);
    end
  endtask

  task automatic test_reset();
    logic exp_t;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      exp_t = (i == 4);
      checks++;
      if (tick !== exp_t || phase !== 3'd0) begin
        errors++;
        $display("FAIL reset_first_tick cycle %0d: tick=%b phase=%0d required tick=%b phase=0",
                 i, tick, phase, exp_t);
      end
      step();
    end
    checks++;
    if (phase !== 3'd1 || ns_light !== 3'b001) begin
      errors++;
      $display("FAIL reset_ns_g_entry: phase=%0d ns=%b required phase=1 ns=001", phase, ns_light);
    end
    repeat (5) step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_obs !== 12'b0_0_0_100_100_000) begin
      errors++;
      $display("FAIL reset_async: obs=%b required=%b", dut_obs, 12'b0_0_0_100_100_000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_free_run();
    int lens[6];
    int cnt, total;
    int p;
    lens = '{AT * DIV, GT * DIV, YT * DIV, AT * DIV, GT * DIV, YT * DIV};
    apply_reset();
    total = 0;
    for (int k = 0; k < 12; k++) begin
      p = k % 6;
      cnt = 0;
      while (phase === 3'(p) && cnt < 100) begin
        cnt++;
        step();
        checks++;
        if (dut_obs !== model_obs()) begin
          errors++;
          $display("FAIL free_run_obs: obs=%b required=%b", dut_obs, model_obs());
        end
      end
      total += cnt;
      checks++;
      if (cnt !== lens[p]) begin
        errors++;
        $display("FAIL free_run_len phase %0d: cycles=%0d required=%0d", p, cnt, lens[p]);
      end
    end
    checks++;
    if (total !== 96) begin
      errors++;
      $display("FAIL free_run_total: cycles=%0d required=96", total);
    end
  endtask

  task automatic test_ped_service();
    int acks, wcnt, wseen, g;
    apply_reset();
    wait_phase(3'd1);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    checks++;
    if (ped_ack !== 1'b1) begin
      errors++;
      $display("FAIL ped_ack_latency: ped_ack=%b required=1", ped_ack);
    end
    acks = 1;
    g = 0;
    while (phase !== 3'd6 && g < 200) begin
      step();
      g++;
      if (ped_ack === 1'b1) acks++;
      checks++;
      if (dut_obs !== model_obs()) begin
        errors++;
        $display("FAIL ped_obs: obs=%b required=%b", dut_obs, model_obs());
      end
    end
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL ped_ack_count: acks=%0d required=1", acks);
    end
    wcnt = 0;
    while (phase === 3'd6 && wcnt < 100) begin
      checks++;
      if (walk !== 1'b1 || ns_light !== 3'b100 || ew_light !== 3'b100) begin
        errors++;
        $display("FAIL ped_walk_lamps: walk=%b ns=%b ew=%b required 1/100/100", walk, ns_light, ew_light);
      end
      wcnt++;
      step();
    end
    checks++;
    if (wcnt !== WT * DIV) begin
      errors++;
      $display("FAIL ped_walk_len: cycles=%0d required=%0d", wcnt, WT * DIV);
    end
    wseen = 0;
    repeat (48) begin
      step();
      if (phase === 3'd6 || walk === 1'b1) wseen++;
    end
    checks++;
    if (wseen !== 0) begin
      errors++;
      $display("FAIL ped_no_repeat: walk cycles=%0d required=0", wseen);
    end
  endtask

  task automatic test_late_request();
    apply_reset();
    wait_phase(3'd5);
    repeat (YT * DIV - 1) step();
    checks++;
    if (tick !== 1'b1 || phase !== 3'd5) begin
      errors++;
      $display("FAIL late_final_tick: tick=%b phase=%0d required tick=1 phase=5", tick, phase);
    end
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    checks++;
    if (phase !== 3'd6 || ped_ack !== 1'b1) begin
      errors++;
      $display("FAIL late_served: phase=%0d ped_ack=%b required phase=6 ped_ack=1", phase, ped_ack);
    end
  endtask

  task automatic test_duplicate();
    int acks, wacks, g;
    apply_reset();
    wait_phase(3'd3);
    ped_req = 1'b1;
    acks = 0;
    repeat (30) begin
      step();
      if (ped_ack === 1'b1) acks++;
      checks++;
      if (dut_obs !== model_obs()) begin
        errors++;
        $display("FAIL dup_obs: obs=%b required=%b", dut_obs, model_obs());
      end
    end
    checks++;
    if (acks !== 1 || phase !== 3'd6) begin
      errors++;
      $display("FAIL dup_single_ack: acks=%0d phase=%0d required acks=1 phase=6", acks, phase);
    end
    wacks = 0;
    g = 0;
    while (phase === 3'd6 && g < 50) begin
      step();
      g++;
      if (ped_ack === 1'b1) wacks++;
    end
    checks++;
    if (wacks !== 0 || phase !== 3'd0) begin
      errors++;
      $display("FAIL dup_walk_ignore: acks=%0d phase=%0d required acks=0 phase=0", wacks, phase);
    end
    step();
    ped_req = 1'b0;
    checks++;
    if (ped_ack !== 1'b1) begin
      errors++;
      $display("FAIL dup_reaccept: ped_ack=%b required=1", ped_ack);
    end
  endtask

  task automatic test_enable_freeze();
    int cnt, g;
    apply_reset();
    wait_phase(3'd4);
    cnt = 1;
    repeat (3) begin
      step();
      cnt++;
    end
    en = 1'b0;
    repeat (20) begin
      step();
      cnt++;
      checks++;
      if (tick !== 1'b0 || phase !== 3'd4 || ew_light !== 3'b001) begin
        errors++;
        $display("FAIL freeze_hold: tick=%b phase=%0d ew=%b required tick=0 phase=4 ew=001",
                 tick, phase, ew_light);
      end
    end
    en = 1'b1;
    g = 0;
    while (phase === 3'd4 && g < 100) begin
      step();
      g++;
      if (phase === 3'd4) cnt++;
    end
    checks++;
    if (cnt !== GT * DIV + 20) begin
      errors++;
      $display("FAIL freeze_len: cycles=%0d required=%0d", cnt, GT * DIV + 20);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      ped_req = ($urandom_range(0, 19) == 0);
      step();
      checks++;
      if (dut_obs !== model_obs()) begin
        errors++;
        $display("FAIL random_obs cycle %0d: obs=%b required=%b", i, dut_obs, model_obs());
      end
    end
    en      = 1'b1;
    ped_req = 1'b0;
  endtask

  task automatic test_max_params();
    int cnt, ticks, g;
    mx_en      = 1'b1;
    mx_ped_req = 1'b0;
    mx_rst_n   = 1'b0;
    @(negedge clk);
    mx_rst_n = 1'b1;
    g = 0;
    while (mx_phase !== 3'd1 && g < 20) begin
      step();
      g++;
    end
    cnt   = 0;
    ticks = 0;
    while (mx_phase === 3'd1 && cnt < 700) begin
      cnt++;
      if (mx_tick === 1'b1) ticks++;
      if (mx_ns_light !== 3'b001 || mx_ew_light !== 3'b100 || mx_walk !== 1'b0 || mx_ped_ack !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL max_lamps: ns=%b ew=%b walk=%b ack=%b required 001/100/0/0",
                 mx_ns_light, mx_ew_light, mx_walk, mx_ped_ack);
      end
      step();
    end
    checks++;
    if (cnt !== 510 || ticks !== 255) begin
      errors++;
      $display("FAIL max_ns_g_len: cycles=%0d ticks=%0d required cycles=510 ticks=255", cnt, ticks);
    end
    checks++;
    if (mx_phase !== 3'd2) begin
      errors++;
      $display("FAIL max_next_phase: phase=%0d required=2", mx_phase);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    ped_req    = 1'b0;
    mx_rst_n   = 1'b0;
    mx_en      = 1'b0;
    mx_ped_req = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_free_run();
    test_ped_service();
    test_late_request();
    test_duplicate();
    test_enable_freeze();
    test_random();
    test_max_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
